// File: rtl/uart_rx_core_if.sv
// Receive-side bundle: serial line in, frame strobe with data and status out.
// Latency: none, wires only.
// Backpressure: none; the consumer must accept every o_wr strobe.
interface uart_rx_core_if #(
    parameter int DATA_BITS = 8
);
    logic                 i_rx_data;
    logic                 o_wr;
    logic [DATA_BITS-1:0] o_data;
    logic                 o_parity_err;
    logic                 o_frame_err;
    logic                 o_break;
    logic                 o_busy;

    // Receiver side: samples the line, produces frames
    modport master (
        input  i_rx_data,
        output o_wr, o_data, o_parity_err, o_frame_err, o_break, o_busy
    );

    // Pin / register-layer side: drives the line, consumes frames
    modport slave (
        output i_rx_data,
        input  o_wr, o_data, o_parity_err, o_frame_err, o_break, o_busy
    );
endinterface

// File: rtl/uart_rx_core.sv
// UART receive engine: sync'd line, start glitch reject, data/parity/stop, per-frame status.
// Latency: o_wr one cycle after the last stop-bit decision; pin-to-rxs is 2 cycles.
// Backpressure: none; o_wr is a one-cycle strobe. Define UART_RX_MAJORITY_EN for 2-of-3 bit voting.
module uart_rx_core #(
    parameter int CLKS_PER_BIT = 10416,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    uart_rx_core_if.master rx
);
    localparam int HALF = CLKS_PER_BIT / 2;
    localparam int CW   = $clog2(CLKS_PER_BIT);
    localparam int IW   = $clog2(DATA_BITS + 1);
`ifdef UART_RX_MAJORITY_EN
    // Vote window is HALF-2..HALF, so the decision lands on the last sample
    localparam int SAMP = HALF;
`else
    localparam int SAMP = HALF - 1;
`endif

    localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_SAMP  = CW'(SAMP);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [IW-1:0] DATA_LAST = IW'(DATA_BITS - 1);
    localparam logic [IW-1:0] STOP_LAST = IW'(STOP_BITS - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_PAR   = 3'd3;
    localparam logic [2:0] S_STOP  = 3'd4;

    logic                 sync1;
    logic                 rxs;
    logic [1:0]           fill;
    logic                 prev_hi;
`ifdef UART_RX_MAJORITY_EN
    logic                 rxs_d2;
`endif
    logic [2:0]           state;
    logic [CW-1:0]        cnt;
    logic [IW-1:0]        idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bit;
    logic                 stop_low;
    logic                 any_high;

    logic fall;
    logic samp_now;
    logic bit_val;
    logic frame_end;
    logic glitch_abort;
    logic par_err;

    // Two-flop synchroniser plus a fill marker so reset values of the sync
    // chain are never mistaken for a real high level on the line
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1   <= 1'b1;
            rxs     <= 1'b1;
            fill    <= 2'b00;
            prev_hi <= 1'b0;
        end else begin
            sync1   <= rx.i_rx_data;
            rxs     <= sync1;
            fill    <= {fill[0], 1'b1};
            prev_hi <= fill[1] & rxs;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    // Second history tap for the 2-of-3 vote
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxs_d2 <= 1'b1;
        end else begin
            rxs_d2 <= prev_hi;
        end
    end

    assign bit_val = (rxs_d2 & prev_hi) | (rxs_d2 & rxs) | (prev_hi & rxs);
`else
    assign bit_val = rxs;
`endif

    assign fall         = (state == S_IDLE) & prev_hi & ~rxs;
    assign samp_now     = (state != S_IDLE) & (cnt == CNT_SAMP);
    assign frame_end    = samp_now & (state == S_STOP) & (idx == STOP_LAST);
    assign glitch_abort = samp_now & (state == S_START) & bit_val;

    // Busy covers the falling edge cycle and drops in the deciding cycle
    assign rx.o_busy = fall | ((state != S_IDLE) & ~frame_end & ~glitch_abort);

    // Parity check over the assembled data word and the received parity bit
    always_comb begin
        par_err = 1'b0;
        if (PARITY == 1) begin
            par_err = ~(^shreg ^ par_bit);
        end else if (PARITY == 2) begin
            par_err = ^shreg ^ par_bit;
        end
    end

    // Frame FSM; the bit counter free-runs mod CLKS_PER_BIT from the edge so
    // each later decision lands exactly one bit period after the previous one
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            cnt      <= '0;
            idx      <= '0;
            shreg    <= '0;
            par_bit  <= 1'b0;
            stop_low <= 1'b0;
            any_high <= 1'b0;
        end else begin
            if (state != S_IDLE) begin
                cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (fall) begin
                        state <= S_START;
                        cnt   <= CNT_ONE;
                    end
                end
                S_START: begin
                    if (samp_now) begin
                        if (bit_val) begin
                            state <= S_IDLE;
                            cnt   <= '0;
                        end else begin
                            state    <= S_DATA;
                            idx      <= '0;
                            stop_low <= 1'b0;
                            any_high <= 1'b0;
                        end
                    end
                end
                S_DATA: begin
                    if (samp_now) begin
                        shreg    <= {bit_val, shreg[DATA_BITS-1:1]};
                        any_high <= any_high | bit_val;
                        if (idx == DATA_LAST) begin
                            idx   <= '0;
                            state <= (PARITY != 0) ? S_PAR : S_STOP;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                S_PAR: begin
                    if (samp_now) begin
                        par_bit  <= bit_val;
                        any_high <= any_high | bit_val;
                        state    <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (samp_now) begin
                        stop_low <= stop_low | ~bit_val;
                        any_high <= any_high | bit_val;
                        if (idx == STOP_LAST) begin
                            state <= S_IDLE;
                            cnt   <= '0;
                            idx   <= '0;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Frame result: strobe plus data/status, all updated together and held
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx.o_wr         <= 1'b0;
            rx.o_data       <= '0;
            rx.o_parity_err <= 1'b0;
            rx.o_frame_err  <= 1'b0;
            rx.o_break      <= 1'b0;
        end else begin
            rx.o_wr <= frame_end;
            if (frame_end) begin
                rx.o_data       <= shreg;
                rx.o_parity_err <= par_err;
                rx.o_frame_err  <= stop_low | ~bit_val;
                rx.o_break      <= ~(any_high | bit_val);
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core: 8N1 and even-parity instances at 16 clocks per bit.
// Latency: expected strobe cycles are computed from the edge cycle T0 of each frame.
// Backpressure: none; a negedge monitor logs every o_wr strobe.
module tb_uart_rx_core;
    localparam int CPB = 16;
`ifdef UART_RX_MAJORITY_EN
    localparam int D = 1;
`else
    localparam int D = 0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    // Cycle index: at a negedge, cyc names the cycle that began at the last posedge
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx_core_if #(.DATA_BITS(8)) if0 ();
    uart_rx_core_if #(.DATA_BITS(8)) if2 ();

    uart_rx_core #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .rx(if0.master));
    uart_rx_core #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .rx(if2.master));

    int         wr0_cyc[$];
    logic [7:0] wr0_dat[$];
    int         wr2_cyc[$];
    logic [7:0] wr2_dat[$];
    logic       wr0_prev = 1'b0;
    int         consec = 0;
    int         busy_rise0 = -1;
    int         busy_fall0 = -1;
    logic       busy_prev0 = 1'b0;

    // Strobe and busy-edge logger, sampled mid-cycle
    always @(negedge clk) begin
        if (if0.o_wr) begin
            wr0_cyc.push_back(cyc);
            wr0_dat.push_back(if0.o_data);
            if (wr0_prev) consec <= consec + 1;
        end
        if (if2.o_wr) begin
            wr2_cyc.push_back(cyc);
            wr2_dat.push_back(if2.o_data);
        end
        wr0_prev <= if0.o_wr;
        if (if0.o_busy && !busy_prev0) busy_rise0 <= cyc;
        if (!if0.o_busy && busy_prev0) busy_fall0 <= cyc;
        busy_prev0 <= if0.o_busy;
    end

    function automatic logic [15:0] f8n1(input logic [7:0] d, input logic stop);
        return {6'b0, stop, d, 1'b0};
    endfunction

    function automatic logic [15:0] f8e1(input logic [7:0] d, input logic p);
        return {5'b0, 1'b1, p, d, 1'b0};
    endfunction

    // Drives bits LSB first, CPB cycles each; caller sits #1 after a posedge
    task automatic send_frame(input int which, input logic [15:0] bits, input int nbits,
                              output int t0);
        t0 = 0;
        for (int i = 0; i < nbits; i++) begin
            if (which == 0) if0.i_rx_data = bits[i];
            else            if2.i_rx_data = bits[i];
            if (i == 0) t0 = cyc + 2;
            repeat (CPB) @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        if0.i_rx_data = 1'b0;
        if2.i_rx_data = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (if0.o_wr !== 1'b0) begin failures++; $display("FAIL rst_wr0 got=%b exp=0", if0.o_wr); end
        checks++; if (if0.o_data !== 8'h00) begin failures++; $display("FAIL rst_data0 got=%h exp=00", if0.o_data); end
        checks++; if (if0.o_busy !== 1'b0) begin failures++; $display("FAIL rst_busy0 got=%b exp=0", if0.o_busy); end
        checks++; if ({if0.o_parity_err, if0.o_frame_err, if0.o_break} !== 3'b000) begin
            failures++; $display("FAIL rst_flags0 got=%b exp=000", {if0.o_parity_err, if0.o_frame_err, if0.o_break}); end
        checks++; if ({if2.o_wr, if2.o_busy, if2.o_parity_err, if2.o_frame_err, if2.o_break} !== 5'b0) begin
            failures++; $display("FAIL rst_ctl2 got=%b exp=00000", {if2.o_wr, if2.o_busy, if2.o_parity_err, if2.o_frame_err, if2.o_break}); end
        rst_n = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        checks++; if (if0.o_busy !== 1'b0) begin failures++; $display("FAIL low_at_release_busy got=%b exp=0", if0.o_busy); end
        checks++; if (wr0_cyc.size() !== 0) begin failures++; $display("FAIL low_at_release_wr got=%0d exp=0", wr0_cyc.size()); end
        if0.i_rx_data = 1'b1;
        repeat (20) @(posedge clk);
        #1;
    endtask

    task automatic test_8n1;
        int t0, n, got;
        n = wr0_cyc.size();
        send_frame(0, f8n1(8'hB5, 1'b1), 10, t0);
        repeat (10) @(posedge clk);
        #1;
        checks++; if (wr0_cyc.size() !== n + 1) begin failures++; $display("FAIL 8n1_count got=%0d exp=%0d", wr0_cyc.size(), n + 1); end
        got = (wr0_cyc.size() > n) ? wr0_cyc[n] - t0 : -1;
        checks++; if (got !== 152 + D) begin failures++; $display("FAIL 8n1_wr_cycle got=T0+%0d exp=T0+%0d", got, 152 + D); end
        checks++; if (if0.o_data !== 8'hB5) begin failures++; $display("FAIL 8n1_data got=%h exp=b5", if0.o_data); end
        checks++; if ({if0.o_parity_err, if0.o_frame_err, if0.o_break} !== 3'b000) begin
            failures++; $display("FAIL 8n1_flags got=%b exp=000", {if0.o_parity_err, if0.o_frame_err, if0.o_break}); end
        checks++; if (busy_rise0 - t0 !== 0) begin failures++; $display("FAIL 8n1_busy_rise got=T0+%0d exp=T0+0", busy_rise0 - t0); end
        checks++; if (busy_fall0 - t0 !== 151 + D) begin failures++; $display("FAIL 8n1_busy_fall got=T0+%0d exp=T0+%0d", busy_fall0 - t0, 151 + D); end
    endtask

    task automatic test_start_glitch;
        int t0, n, got;
        n = wr0_cyc.size();
        if0.i_rx_data = 1'b0;
        t0 = cyc + 2;
        repeat (3) @(posedge clk);
        #1;
        if0.i_rx_data = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        checks++; if (wr0_cyc.size() !== n) begin failures++; $display("FAIL glitch_no_wr got=%0d exp=%0d", wr0_cyc.size(), n); end
        checks++; if (busy_fall0 - t0 !== 7 + D) begin failures++; $display("FAIL glitch_busy_fall got=T0+%0d exp=T0+%0d", busy_fall0 - t0, 7 + D); end
        send_frame(0, f8n1(8'h3C, 1'b1), 10, t0);
        repeat (10) @(posedge clk);
        #1;
        got = (wr0_cyc.size() > n) ? wr0_cyc[n] - t0 : -1;
        checks++; if (got !== 152 + D) begin failures++; $display("FAIL glitch_next_cycle got=T0+%0d exp=T0+%0d", got, 152 + D); end
        checks++; if (if0.o_data !== 8'h3C) begin failures++; $display("FAIL glitch_next_data got=%h exp=3c", if0.o_data); end
    endtask

    task automatic test_parity;
        int t0, n, got;
        n = wr2_cyc.size();
        send_frame(2, f8e1(8'h03, 1'b1), 11, t0);
        repeat (10) @(posedge clk);
        #1;
        got = (wr2_cyc.size() > n) ? wr2_cyc[n] - t0 : -1;
        checks++; if (got !== 168 + D) begin failures++; $display("FAIL par_wr_cycle got=T0+%0d exp=T0+%0d", got, 168 + D); end
        checks++; if (if2.o_data !== 8'h03) begin failures++; $display("FAIL par_bad_data got=%h exp=03", if2.o_data); end
        checks++; if (if2.o_parity_err !== 1'b1) begin failures++; $display("FAIL par_bad_flag got=%b exp=1", if2.o_parity_err); end
        checks++; if (if2.o_frame_err !== 1'b0) begin failures++; $display("FAIL par_bad_frame got=%b exp=0", if2.o_frame_err); end
        send_frame(2, f8e1(8'h03, 1'b0), 11, t0);
        repeat (10) @(posedge clk);
        #1;
        checks++; if (wr2_cyc.size() !== n + 2) begin failures++; $display("FAIL par_count got=%0d exp=%0d", wr2_cyc.size(), n + 2); end
        checks++; if (if2.o_parity_err !== 1'b0) begin failures++; $display("FAIL par_good_flag got=%b exp=0", if2.o_parity_err); end
        checks++; if (if2.o_data !== 8'h03) begin failures++; $display("FAIL par_good_data got=%h exp=03", if2.o_data); end
    endtask

    task automatic test_break;
        int t0, n, got;
        n = wr0_cyc.size();
        send_frame(0, f8n1(8'h00, 1'b0), 10, t0);
        got = (wr0_cyc.size() > n) ? wr0_cyc[n] - t0 : -1;
        checks++; if (got !== 152 + D) begin failures++; $display("FAIL brk_wr_cycle got=T0+%0d exp=T0+%0d", got, 152 + D); end
        checks++; if ({if0.o_frame_err, if0.o_break, if0.o_parity_err} !== 3'b110) begin
            failures++; $display("FAIL brk_flags got=%b exp=110", {if0.o_frame_err, if0.o_break, if0.o_parity_err}); end
        checks++; if (if0.o_data !== 8'h00) begin failures++; $display("FAIL brk_data got=%h exp=00", if0.o_data); end
        repeat (200) @(posedge clk);
        #1;
        checks++; if (wr0_cyc.size() !== n + 1) begin failures++; $display("FAIL brk_held_low_wr got=%0d exp=%0d", wr0_cyc.size(), n + 1); end
        checks++; if (if0.o_busy !== 1'b0) begin failures++; $display("FAIL brk_held_low_busy got=%b exp=0", if0.o_busy); end
        if0.i_rx_data = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        send_frame(0, f8n1(8'h55, 1'b1), 10, t0);
        repeat (10) @(posedge clk);
        #1;
        got = (wr0_cyc.size() > n + 1) ? wr0_cyc[n + 1] - t0 : -1;
        checks++; if (got !== 152 + D) begin failures++; $display("FAIL brk_rearm_cycle got=T0+%0d exp=T0+%0d", got, 152 + D); end
        checks++; if (if0.o_data !== 8'h55) begin failures++; $display("FAIL brk_rearm_data got=%h exp=55", if0.o_data); end
        checks++; if ({if0.o_frame_err, if0.o_break} !== 2'b00) begin
            failures++; $display("FAIL brk_rearm_flags got=%b exp=00", {if0.o_frame_err, if0.o_break}); end
    endtask

    task automatic test_back_to_back;
        int t0a, t0b, n, gap;
        n = wr0_cyc.size();
        send_frame(0, f8n1(8'h5A, 1'b1), 10, t0a);
        send_frame(0, f8n1(8'hA5, 1'b1), 10, t0b);
        repeat (10) @(posedge clk);
        #1;
        checks++; if (wr0_cyc.size() !== n + 2) begin failures++; $display("FAIL b2b_count got=%0d exp=%0d", wr0_cyc.size(), n + 2); end
        gap = (wr0_cyc.size() > n + 1) ? wr0_cyc[n + 1] - wr0_cyc[n] : -1;
        checks++; if (gap !== 160) begin failures++; $display("FAIL b2b_gap got=%0d exp=160", gap); end
        checks++; if (wr0_dat.size() > n + 1 && (wr0_dat[n] !== 8'h5A || wr0_dat[n + 1] !== 8'hA5)) begin
            failures++; $display("FAIL b2b_data got=%h,%h exp=5a,a5", wr0_dat[n], wr0_dat[n + 1]); end
        checks++; if (consec !== 0) begin failures++; $display("FAIL wr_consecutive got=%0d exp=0", consec); end
    endtask

    task automatic test_reset_mid;
        int t0, n;
        n = wr0_cyc.size();
        if0.i_rx_data = 1'b0;
        repeat (CPB + 3 * CPB + 8) @(posedge clk);
        #1;
        checks++; if (if0.o_busy !== 1'b1) begin failures++; $display("FAIL mid_busy_before got=%b exp=1", if0.o_busy); end
        rst_n = 1'b0;
        #2;
        checks++; if ({if0.o_wr, if0.o_busy, if0.o_parity_err, if0.o_frame_err, if0.o_break} !== 5'b0) begin
            failures++; $display("FAIL mid_rst_ctl got=%b exp=00000", {if0.o_wr, if0.o_busy, if0.o_parity_err, if0.o_frame_err, if0.o_break}); end
        checks++; if (if0.o_data !== 8'h00) begin failures++; $display("FAIL mid_rst_data got=%h exp=00", if0.o_data); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (60) @(posedge clk);
        #1;
        if0.i_rx_data = 1'b1;
        repeat (200) @(posedge clk);
        #1;
        checks++; if (wr0_cyc.size() !== n) begin failures++; $display("FAIL mid_rst_no_wr got=%0d exp=%0d", wr0_cyc.size(), n); end
        send_frame(0, f8n1(8'h81, 1'b1), 10, t0);
        repeat (10) @(posedge clk);
        #1;
        checks++; if (if0.o_data !== 8'h81) begin failures++; $display("FAIL mid_rst_recover got=%h exp=81", if0.o_data); end
    endtask

`ifdef UART_RX_MAJORITY_EN
    task automatic test_majority_glitch;
        int t0, n, got;
        n = wr0_cyc.size();
        if0.i_rx_data = 1'b0;
        t0 = cyc + 2;
        repeat (71) @(posedge clk);
        #1;
        if0.i_rx_data = 1'b1;
        @(posedge clk);
        #1;
        if0.i_rx_data = 1'b0;
        repeat (72) @(posedge clk);
        #1;
        if0.i_rx_data = 1'b1;
        repeat (CPB + 10) @(posedge clk);
        #1;
        got = (wr0_cyc.size() > n) ? wr0_cyc[n] - t0 : -1;
        checks++; if (got !== 153) begin failures++; $display("FAIL maj_wr_cycle got=T0+%0d exp=T0+153", got); end
        checks++; if (if0.o_data !== 8'h00) begin failures++; $display("FAIL maj_data got=%h exp=00", if0.o_data); end
        checks++; if ({if0.o_frame_err, if0.o_break} !== 2'b00) begin
            failures++; $display("FAIL maj_flags got=%b exp=00", {if0.o_frame_err, if0.o_break}); end
    endtask
`endif

    initial begin
        if0.i_rx_data = 1'b1;
        if2.i_rx_data = 1'b1;
        test_reset();
        test_8n1();
        test_start_glitch();
        test_parity();
        test_break();
        test_back_to_back();
        test_reset_mid();
`ifdef UART_RX_MAJORITY_EN
        test_majority_glitch();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
